clkgen_div_array: RTL and testbench

CLKGEN_DIV_ARRAY -- requirements
Module: clkgen_div_array

---
 rtl/clkgen_div_array_pkg.sv | 32 +++
 rtl/clkgen_div_array_ch.sv | 45 ++++
 rtl/clkgen_div_array.sv | 115 +++++++++++
 tb/tb_clkgen_div_array.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_div_array_pkg.sv
// Shared types for the divided-clock array: sequencer states and the
// config clamp applied to every shadow-register write.
package clkgen_div_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_LOCKING,
        ST_RUN
    } state_t;

    localparam int unsigned CFG_W = 32;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] high;
        logic [CFG_W-1:0] phase;
    } cfg_t;

    // div is clamped first; high and phase are bounded by the clamped div
    function automatic cfg_t clamp_cfg(input logic [CFG_W-1:0] div,
                                       input logic [CFG_W-1:0] high,
                                       input logic [CFG_W-1:0] phase);
        cfg_t c;
        c.div   = (div < CFG_W'(2)) ? CFG_W'(2) : div;
        c.high  = (high == '0)  ? CFG_W'(1)
                : (high >= c.div) ? c.div - CFG_W'(1) : high;
        c.phase = (phase >= c.div) ? c.div - CFG_W'(1) : phase;
        return c;
    endfunction

endpackage

// File: rtl/clkgen_div_array_ch.sv
// One divider channel: active period/high-time, phase-preloaded counter,
// registered outclk and first-high-cycle clk_en pulse.
module clkgen_div_ch #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] sh_div,
    input  logic [DIV_W-1:0] sh_high,
    input  logic [DIV_W-1:0] sh_phase,
    output logic             outclk,
    output logic             clk_en
);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] high;
    logic [DIV_W-1:0] cnt;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            div    <= DIV_W'(2);
            high   <= DIV_W'(1);
            cnt    <= '0;
            outclk <= 1'b0;
            clk_en <= 1'b0;
        end else if (load) begin
            // preloading div-phase makes the first zero crossing land phase cycles late
            div    <= sh_div;
            high   <= sh_high;
            cnt    <= (sh_phase == '0) ? '0 : sh_div - sh_phase;
            outclk <= 1'b0;
            clk_en <= 1'b0;
        end else if (run) begin
            cnt    <= (cnt == div - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
            outclk <= (cnt < high);
            clk_en <= (cnt == '0);
        end else begin
            outclk <= 1'b0;
            clk_en <= 1'b0;
        end
    end

endmodule

// File: rtl/clkgen_div_array.sv
// Array of programmable refclk dividers with shadow/active config, an
// align-lock-run sequencer and a lock indicator.
module clkgen_div_array
    import clkgen_div_array_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned LOCK_CYC = 8
) (
    input  logic                                          refclk,
    input  logic                                          rst,
    input  logic                                          enable,
    input  logic                                          cfg_valid,
    output logic                                          cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]                              cfg_div,
    input  logic [DIV_W-1:0]                              cfg_high,
    input  logic [DIV_W-1:0]                              cfg_phase,
    input  logic                                          cfg_apply,
    output logic [NUM_CH-1:0]                             outclk,
    output logic [NUM_CH-1:0]                             clk_en,
    output logic                                          locked
);

    localparam int unsigned LK_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

    state_t          state;
    logic [LK_W-1:0] lock_cnt;
    logic            wr;
    logic            load;
    logic            run;
    cfg_t            wcfg;

    logic [DIV_W-1:0] sh_div   [NUM_CH];
    logic [DIV_W-1:0] sh_high  [NUM_CH];
    logic [DIV_W-1:0] sh_phase [NUM_CH];

    assign wr   = cfg_valid && cfg_ready && (32'(cfg_ch) < NUM_CH);
    assign wcfg = clamp_cfg(32'(cfg_div), 32'(cfg_high), 32'(cfg_phase));
    assign load = enable && (state == ST_ALIGN);
    assign run  = enable && ((state == ST_LOCKING) || (state == ST_RUN));

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                sh_div[i]   <= DIV_W'(2);
                sh_high[i]  <= DIV_W'(1);
                sh_phase[i] <= '0;
            end
        end else if (wr) begin
            sh_div[cfg_ch]   <= DIV_W'(wcfg.div);
            sh_high[cfg_ch]  <= DIV_W'(wcfg.high);
            sh_phase[cfg_ch] <= DIV_W'(wcfg.phase);
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            lock_cnt  <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
        end else if (!enable) begin
            state     <= ST_IDLE;
            lock_cnt  <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state     <= ST_ALIGN;
                    cfg_ready <= 1'b0;
                end
                ST_ALIGN: begin
                    state    <= ST_LOCKING;
                    lock_cnt <= '0;
                end
                ST_LOCKING: begin
                    if (lock_cnt == LK_W'(LOCK_CYC - 1)) begin
                        state     <= ST_RUN;
                        locked    <= 1'b1;
                        cfg_ready <= 1'b1;
                    end else begin
                        lock_cnt <= lock_cnt + LK_W'(1);
                    end
                end
                ST_RUN: begin
                    if (cfg_apply) begin
                        state     <= ST_ALIGN;
                        locked    <= 1'b0;
                        cfg_ready <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkgen_div_ch #(
            .DIV_W(DIV_W)
        ) u_ch (
            .refclk  (refclk),
            .rst     (rst),
            .load    (load),
            .run     (run),
            .sh_div  (sh_div[g]),
            .sh_high (sh_high[g]),
            .sh_phase(sh_phase[g]),
            .outclk  (outclk[g]),
            .clk_en  (clk_en[g])
        );
    end

endmodule

// File: tb/tb_clkgen_div_array.sv
// Scoreboard bench: a timestamp-based reference model pushes the expected
// outputs of each refclk edge; a negedge monitor pops and compares.
module tb_clkgen_div_array;

    localparam int unsigned NCH = 3;
    localparam int unsigned DW  = 16;
    localparam int unsigned LK  = 6;
    localparam int unsigned CW  = 2;

    logic           refclk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_apply = 1'b0;
    logic [CW-1:0]  cfg_ch = '0;
    logic [DW-1:0]  cfg_div = '0;
    logic [DW-1:0]  cfg_high = '0;
    logic [DW-1:0]  cfg_phase = '0;
    logic           cfg_ready;
    logic [NCH-1:0] outclk;
    logic [NCH-1:0] clk_en;
    logic           locked;

    clkgen_div_array #(
        .NUM_CH  (NCH),
        .DIV_W   (DW),
        .LOCK_CYC(LK)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .enable   (enable),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
        .cfg_phase(cfg_phase),
        .cfg_apply(cfg_apply),
        .outclk   (outclk),
        .clk_en   (clk_en),
        .locked   (locked)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic [NCH-1:0] oc;
        logic [NCH-1:0] ce;
        logic           lk;
        logic           rdy;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // reference model: active/shadow config plus the edge index of the last
    // enable rise or accepted apply; everything else follows from elapsed time
    int a_div[NCH], a_high[NCH], a_ph[NCH];
    int s_div[NCH], s_high[NCH], s_ph[NCH];
    bit m_busy, m_lk, m_rdy;
    int m_trig, m_n = 0;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            a_div[i] = 2; a_high[i] = 1; a_ph[i] = 0;
            s_div[i] = 2; s_high[i] = 1; s_ph[i] = 0;
        end
        m_busy = 0; m_lk = 0; m_rdy = 0; m_trig = 0;
    endtask

    task automatic push_zero();
        exp_t e;
        e.oc = '0; e.ce = '0; e.lk = 1'b0; e.rdy = 1'b0;
        sb.push_back(e);
    endtask

    task automatic model_step();
        exp_t e;
        int d, init, c, nd, nh, np;
        bit acc;
        e.oc = '0; e.ce = '0; e.lk = 1'b0; e.rdy = 1'b0;
        acc = cfg_valid && m_rdy;
        if (!enable) begin
            m_busy = 0;
            e.rdy = 1'b1;
        end else if (!m_busy) begin
            m_busy = 1;
            m_trig = m_n;
        end else begin
            d = m_n - m_trig;
            if (d == 1) begin
                for (int i = 0; i < NCH; i++) begin
                    a_div[i] = s_div[i]; a_high[i] = s_high[i]; a_ph[i] = s_ph[i];
                end
            end
            if (d >= 2) begin
                for (int i = 0; i < NCH; i++) begin
                    init = (a_ph[i] == 0) ? 0 : a_div[i] - a_ph[i];
                    c = (init + d - 2) % a_div[i];
                    e.oc[i] = (c < a_high[i]);
                    e.ce[i] = (c == 0);
                end
            end
            e.lk  = (d >= int'(LK) + 1);
            e.rdy = e.lk;
            if (m_lk && cfg_apply) begin
                m_trig = m_n;
                e.lk = 1'b0;
                e.rdy = 1'b0;
            end
        end
        if (acc && int'(cfg_ch) < int'(NCH)) begin
            nd = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
            nh = (cfg_high == 0) ? 1 : ((int'(cfg_high) >= nd) ? nd - 1 : int'(cfg_high));
            np = (int'(cfg_phase) >= nd) ? nd - 1 : int'(cfg_phase);
            s_div[cfg_ch] = nd; s_high[cfg_ch] = nh; s_ph[cfg_ch] = np;
        end
        m_lk = e.lk;
        m_rdy = e.rdy;
        m_n++;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge refclk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("outclk",    32'(outclk),    32'(e.oc));
                chk("clk_en",    32'(clk_en),    32'(e.ce));
                chk("locked",    32'(locked),    32'(e.lk));
                chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
            end
        end
    end

    task automatic tick(input bit en, input bit v, input int ch, input int dv,
                        input int hi, input int ph, input bit ap);
        @(posedge refclk); #1;
        model_step();
        enable    = en;
        cfg_valid = v;
        cfg_ch    = CW'(ch);
        cfg_div   = DW'(dv);
        cfg_high  = DW'(hi);
        cfg_phase = DW'(ph);
        cfg_apply = ap;
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) tick(en, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge refclk); #1;
        rst = 1'b1;
        enable = 1'b0; cfg_valid = 1'b0; cfg_apply = 1'b0;
        push_zero();
        @(posedge refclk); #1;
        push_zero();
        rst = 1'b0;
        model_reset();
        m_n++;
    endtask

    initial begin : stim
        model_reset();
        do_reset();
        idle(1, 0);
        idle(LK + 12, 1);
        // reconfigure in RUN; apply lands together with the last write
        tick(1, 1, 0, 5, 2, 0, 0);
        tick(1, 1, 1, 5, 2, 3, 0);
        tick(1, 1, 2, 0, 9, 0, 1);
        idle(30, 1);
        // out-of-range channel write must leave every channel unchanged
        tick(1, 1, 3, 7, 3, 1, 1);
        idle(3, 1);
        tick(1, 0, 0, 0, 0, 0, 1);
        idle(LK + 15, 1);
        // enable drop while locking
        tick(1, 1, 2, 9, 4, 12, 1);
        idle(3, 1);
        tick(0, 0, 0, 0, 0, 0, 0);
        idle(2, 0);
        idle(LK + 20, 1);
        // reset in the middle of RUN
        do_reset();
        idle(2, 0);
        idle(LK + 10, 1);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(599) == 0) begin
                do_reset();
            end else begin
                tick($urandom_range(79) != 0, $urandom_range(3) == 0,
                     int'($urandom_range(3)), int'($urandom_range(9)),
                     int'($urandom_range(9)), int'($urandom_range(9)),
                     $urandom_range(24) == 0);
            end
        end
        idle(4, 1);
        @(negedge refclk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
